header_block_rdr: RTL and testbench
===================================

// Module: header_block_rdr
// PURPOSE
// - APB initiator that reads and decodes a remote header block (drawing number, version/revision/build date).
// - Sits beside the system bus master. After reset, or on request, it reads both header words and publishes
//   decoded identity fields plus a match flag against expected values.
// - Provides the boot-time firmware/gateware identity check for the board.
// PARAMETERS
// - ADDR_W       default 16           APB address width
// - BASE_ADDR    default 16'h0000     byte address of the header block on the APB segment
// - AUTO_START   default 1            1: begin one read sequence on the first cycle after reset release
// - EXP_DRAWING  default 32'h08000101 expected drawing number
// - EXP_VERSION  default 4'h1         expected version field
// - TIMEOUT_CYC  default 256          max ACCESS cycles per transfer (used only with the timeout feature)
// PORTS
// - clk_i              in   1       clock
// - rst_i              in   1       synchronous reset, active-high
// - start_i            in   1       pulse: launch a read sequence; ignored while busy_o=1
// - m_psel_o           out  1       APB select
// - m_penable_o        out  1       APB enable
// - m_pwrite_o         out  1       APB write; tied to 0
// - m_paddr_o          out  ADDR_W  APB address
// - m_prdata_i         in   32      APB read data
// - m_pready_i         in   1       APB ready
// - m_pslverr_i        in   1       APB error
// - busy_o             out  1       sequence in progress
// - done_o             out  1       1-cycle pulse when a sequence ends, on success or error
// - valid_o            out  1       decoded fields hold data from a good sequence
// - err_o              out  1       last sequence failed (PSLVERR or timeout); sticky until next start
// - drawing_number_o   out  32      word 0x0
// - version_o          out  4       word 0x4 bits [3:0]
// - revision_o         out  8       word 0x4 bits [11:4]
// - build_date_o       out  20      word 0x4 bits [31:12]
// - id_match_o         out  1       valid_o && drawing==EXP_DRAWING && version==EXP_VERSION
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, bus idle (psel=penable=0, paddr=0). Reset mid-transfer aborts on the same edge.
// - FSM states and transitions:
//   - IDLE -> SETUP on start_i, or on the first post-reset cycle if AUTO_START=1.
//     On this transition: clear valid_o, err_o and id_match_o; select word index 0.
//   - SETUP (psel=1, penable=0, paddr=BASE_ADDR+4*idx), 1 cycle -> ACCESS.
//   - ACCESS (psel=1, penable=1; paddr held stable) waits for pready.
//   - On pready && !pslverr: capture prdata into word[idx].
//     - idx=0 -> SETUP with idx=1.
//     - idx=1 -> DONE.
//   - On pready && pslverr -> ERROR.
//   - DONE: 1 cycle; done_o=1, valid_o<=1, fields and id_match_o updated -> IDLE.
//   - ERROR: 1 cycle; done_o=1, err_o<=1, valid_o stays 0 -> IDLE.
// - Bus timing: psel and penable drop in the cycle after the accepting pready. There are no back-to-back
//   ACCESS states; every transfer starts with SETUP.
// - Latency with zero-wait-state slave: start_i at cycle 0 -> done_o at cycle 5.
// - Fields: fields update only in DONE, from registered captures. Partial data from an errored sequence is never published.
// - busy_o is 1 from the cycle after start until done_o inclusive. start_i asserted together with done_o is ignored.
// - id_match_o is a registered compare, valid in the same cycle as valid_o.
// CONFIGURATION
// - HEADER_BLOCK_RDR_TIMEOUT_EN defined:
//   - a $clog2(TIMEOUT_CYC+1)-bit counter runs in ACCESS and clears in SETUP.
//   - when TIMEOUT_CYC cycles elapse without pready: drop psel/penable and go to ERROR.
// - HEADER_BLOCK_RDR_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYC is unused.
// STRUCTURE
// - Package header_block_rdr_pkg:
//   - state enum typedef
//   - word offsets 'h0 and 'h4
//   - field offsets 0/4/12 and masks 32'hf / 32'hff0 / 32'hfffff000
//   - field widths 4/8/20
// - Single module, no sub-module. The APB phase logic is too small to split out.
// TESTING
// - Zero-wait slave, word0=32'h08000101, word1=32'h3840F001: done at cycle 5, version=1, revision=0,
//   build_date=20'h3840F, id_match_o=1.
// - 3 wait states per transfer: paddr stable through ACCESS; done_o at cycle 11; no psel glitch between transfers.
// - Drawing word returns 32'h08000102: valid_o=1, id_match_o=0.
// - PSLVERR on the second transfer: err_o=1, valid_o=0, fields keep the values from the prior good run.
// - Timeout (TIMEOUT_EN defined, TIMEOUT_CYC=4, pready never asserted): ERROR after 4 ACCESS cycles, psel=0.
//   Without the macro the bench sees busy_o held high.
// - rst_i asserted in ACCESS: next cycle psel=0 and all outputs 0. start_i while busy: no second sequence.

Source files
------------

// File: rtl/header_block_rdr_pkg.sv
// Shared types and constants for header_block_rdr: FSM states, header word offsets,
// identity field layout and field extraction helpers.
package header_block_rdr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [31:0] WORD0_OFF = 32'h0000_0000;
    localparam logic [31:0] WORD1_OFF = 32'h0000_0004;

    localparam int VER_LSB  = 0;
    localparam int REV_LSB  = 4;
    localparam int DATE_LSB = 12;

    localparam logic [31:0] VER_MASK  = 32'h0000_000f;
    localparam logic [31:0] REV_MASK  = 32'h0000_0ff0;
    localparam logic [31:0] DATE_MASK = 32'hffff_f000;

    localparam int VER_W  = 4;
    localparam int REV_W  = 8;
    localparam int DATE_W = 20;

    function automatic logic [VER_W-1:0] get_version(input logic [31:0] w);
        logic [31:0] t;
        t = (w & VER_MASK) >> VER_LSB;
        return t[VER_W-1:0];
    endfunction

    function automatic logic [REV_W-1:0] get_revision(input logic [31:0] w);
        logic [31:0] t;
        t = (w & REV_MASK) >> REV_LSB;
        return t[REV_W-1:0];
    endfunction

    function automatic logic [DATE_W-1:0] get_build_date(input logic [31:0] w);
        logic [31:0] t;
        t = (w & DATE_MASK) >> DATE_LSB;
        return t[DATE_W-1:0];
    endfunction

endpackage

// File: rtl/header_block_rdr.sv
// APB initiator that reads the two-word header block and publishes decoded identity fields.
// Optional ACCESS-phase timeout is enabled with the HEADER_BLOCK_RDR_TIMEOUT_EN macro.
module header_block_rdr
    import header_block_rdr_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(16'h0000),
    parameter int                AUTO_START  = 1,
    parameter logic [31:0]       EXP_DRAWING = 32'h0800_0101,
    parameter logic [3:0]        EXP_VERSION = 4'h1,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              m_psel_o,
    output logic              m_penable_o,
    output logic              m_pwrite_o,
    output logic [ADDR_W-1:0] m_paddr_o,
    input  logic [31:0]       m_prdata_i,
    input  logic              m_pready_i,
    input  logic              m_pslverr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    output logic              err_o,
    output logic [31:0]       drawing_number_o,
    output logic [3:0]        version_o,
    output logic [7:0]        revision_o,
    output logic [19:0]       build_date_o,
    output logic              id_match_o
);

    state_e              state_q, state_d;
    logic                idx_q, idx_d;
    logic                auto_q, auto_d;
    logic [31:0]         word0_q, word0_d, word1_q, word1_d;
    logic                psel_q, psel_d, penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                valid_q, valid_d, err_q, err_d, match_q, match_d;
    logic [31:0]         draw_q, draw_d;
    logic [VER_W-1:0]    ver_q, ver_d;
    logic [REV_W-1:0]    rev_q, rev_d;
    logic [DATE_W-1:0]   date_q, date_d;
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Next-state, capture and registered-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        auto_d  = auto_q;
        word0_d = word0_q;
        word1_d = word1_q;
        valid_d = valid_q;
        err_d   = err_q;
        match_d = match_q;
        draw_d  = draw_q;
        ver_d   = ver_q;
        rev_d   = rev_q;
        date_d  = date_q;
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i || auto_q) begin
                    state_d = ST_SETUP;
                    idx_d   = 1'b0;
                    auto_d  = 1'b0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    match_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (m_pready_i) begin
                    if (m_pslverr_i) begin
                        state_d = ST_ERROR;
                    end else if (idx_q == 1'b0) begin
                        word0_d = m_prdata_i;
                        idx_d   = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        word1_d = m_prdata_i;
                        state_d = ST_DONE;
                    end
                end else begin
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ST_ACCESS;
`endif
                end
            end
            ST_DONE: begin
                // Publish only from the registered captures of a fully good sequence
                state_d = ST_IDLE;
                valid_d = 1'b1;
                draw_d  = word0_q;
                ver_d   = get_version(word1_q);
                rev_d   = get_revision(word1_q);
                date_d  = get_build_date(word1_q);
                match_d = (word0_q == EXP_DRAWING) && (get_version(word1_q) == EXP_VERSION);
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE) || (state_d == ST_ERROR);
        if (state_d == ST_SETUP) begin
            paddr_d = BASE_ADDR + ADDR_W'(idx_d ? WORD1_OFF : WORD0_OFF);
        end else begin
            paddr_d = paddr_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= 1'b0;
            auto_q    <= (AUTO_START != 0);
            word0_q   <= 32'h0;
            word1_q   <= 32'h0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            match_q   <= 1'b0;
            draw_q    <= 32'h0;
            ver_q     <= '0;
            rev_q     <= '0;
            date_q    <= '0;
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            auto_q    <= auto_d;
            word0_q   <= word0_d;
            word1_q   <= word1_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            match_q   <= match_d;
            draw_q    <= draw_d;
            ver_q     <= ver_d;
            rev_q     <= rev_d;
            date_q    <= date_d;
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign m_psel_o         = psel_q;
    assign m_penable_o      = penable_q;
    assign m_pwrite_o       = 1'b0;
    assign m_paddr_o        = paddr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign valid_o          = valid_q;
    assign err_o            = err_q;
    assign id_match_o       = match_q;
    assign drawing_number_o = draw_q;
    assign version_o        = ver_q;
    assign revision_o       = rev_q;
    assign build_date_o     = date_q;

endmodule

// File: tb/tb_header_block_rdr.sv
// Randomized self-checking bench for header_block_rdr with a behavioural APB slave and
// a field-level reference model; follows HEADER_BLOCK_RDR_TIMEOUT_EN for the timeout scenario.
module tb_header_block_rdr;

`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        m_psel_o, m_penable_o, m_pwrite_o;
    logic [15:0] m_paddr_o;
    logic [31:0] m_prdata_i = 32'h0;
    logic        m_pready_i = 1'b0;
    logic        m_pslverr_i = 1'b0;
    logic        busy_o, done_o, valid_o, err_o, id_match_o;
    logic [31:0] drawing_number_o;
    logic [3:0]  version_o;
    logic [7:0]  revision_o;
    logic [19:0] build_date_o;

    int checks = 0;
    int errors = 0;

    // slave configuration and state
    int          s_wait = 0;
    int          err_xfer = -1;
    int          xfer = 0;
    int          wcnt = 0;
    bit          no_ready = 1'b0;
    logic [31:0] mem0 = 32'h0, mem1 = 32'h0;

    // reference model of the published identity
    logic        m_valid, m_err, m_match;
    logic [31:0] m_draw;
    logic [3:0]  m_ver;
    logic [7:0]  m_rev;
    logic [19:0] m_date;

    header_block_rdr #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
        .m_paddr_o(m_paddr_o), .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i),
        .m_pslverr_i(m_pslverr_i), .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o),
        .err_o(err_o), .drawing_number_o(drawing_number_o), .version_o(version_o),
        .revision_o(revision_o), .build_date_o(build_date_o), .id_match_o(id_match_o)
    );

    always #5 clk = ~clk;

    // APB slave: s_wait wait states per transfer, optional PSLVERR on transfer err_xfer
    always @(negedge clk) begin
        if (m_psel_o && m_penable_o && !no_ready) begin
            if (wcnt == s_wait) begin
                m_pready_i  = 1'b1;
                m_prdata_i  = (m_paddr_o == 16'h0004) ? mem1 : mem0;
                m_pslverr_i = (xfer == err_xfer);
                xfer        = xfer + 1;
                wcnt        = 0;
            end else begin
                m_pready_i  = 1'b0;
                m_pslverr_i = 1'b0;
                m_prdata_i  = $urandom;
                wcnt        = wcnt + 1;
            end
        end else begin
            m_pready_i  = 1'b0;
            m_pslverr_i = 1'b0;
            wcnt        = 0;
        end
    end

    task automatic model_reset();
        m_valid = 1'b0; m_err = 1'b0; m_match = 1'b0;
        m_draw = 32'h0; m_ver = 4'h0; m_rev = 8'h0; m_date = 20'h0;
    endtask

    task automatic model_good(input logic [31:0] d0, input logic [31:0] d1);
        m_valid = 1'b1;
        m_err   = 1'b0;
        m_draw  = d0;
        m_ver   = 4'(d1 % 32'd16);
        m_rev   = 8'((d1 / 32'd16) % 32'd256);
        m_date  = 20'(d1 / 32'd4096);
        m_match = (d0 == 32'h0800_0101) && (m_ver == 4'h1);
    endtask

    task automatic model_error();
        m_valid = 1'b0;
        m_err   = 1'b1;
        m_match = 1'b0;
    endtask

    // Drives one sequence (start pulse or auto-start) and observes the bus until done_o
    task automatic run_seq(input bit use_start, input int w, input int errx,
                           input logic [31:0] d0, input logic [31:0] d1,
                           output int done_k, output int proto_errs);
        bit          saw_psel;
        int          nsetup;
        logic [15:0] last_addr;
        s_wait = w; err_xfer = errx; mem0 = d0; mem1 = d1; xfer = 0; no_ready = 1'b0;
        saw_psel = 1'b0; nsetup = 0; last_addr = 16'h0;
        done_k = -1; proto_errs = 0;
        start_i = use_start;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (!busy_o) proto_errs++;
            if (m_psel_o) saw_psel = 1'b1;
            if (saw_psel && !m_psel_o && !done_o) proto_errs++;
            if (m_psel_o && !m_penable_o) begin
                if (m_paddr_o != 16'(4 * nsetup)) proto_errs++;
                last_addr = m_paddr_o;
                nsetup++;
            end
            if (m_psel_o && m_penable_o && (m_paddr_o != last_addr)) proto_errs++;
            if (m_pwrite_o !== 1'b0) proto_errs++;
            if (done_o) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_psel_o, m_penable_o, m_paddr_o, busy_o, done_o} !== 20'h0) begin
            errors++;
            $display("FAIL reset_bus: got %0h expected 0", {m_psel_o, m_penable_o, m_paddr_o, busy_o, done_o});
        end
        checks++;
        if ({valid_o, err_o, id_match_o, drawing_number_o, version_o, revision_o, build_date_o} !== 67'h0) begin
            errors++;
            $display("FAIL reset_fields: valid=%b err=%b match=%b draw=%h expected all 0",
                     valid_o, err_o, id_match_o, drawing_number_o);
        end
    endtask

    task automatic test_auto_start();
        int dk, pe;
        rst_i = 1'b0;
        run_seq(1'b0, 0, -1, 32'h0800_0101, 32'h3840_F001, dk, pe);
        checks++;
        if (dk !== 5) begin errors++; $display("FAIL auto_latency: got %0d expected 5", dk); end
        checks++;
        if (pe !== 0) begin errors++; $display("FAIL auto_protocol: got %0d violations expected 0", pe); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL auto_valid_at_done: got %b expected 0", valid_o); end
        model_good(32'h0800_0101, 32'h3840_F001);
        @(posedge clk); #1;
        checks++;
        if ({valid_o, err_o, id_match_o} !== {m_valid, m_err, m_match}) begin
            errors++;
            $display("FAIL auto_flags: got %b%b%b expected %b%b%b", valid_o, err_o, id_match_o, m_valid, m_err, m_match);
        end
        checks++;
        if ({drawing_number_o, version_o, revision_o, build_date_o} !== {m_draw, m_ver, m_rev, m_date}) begin
            errors++;
            $display("FAIL auto_fields: got %h/%h/%h/%h expected %h/%h/%h/%h", drawing_number_o, version_o,
                     revision_o, build_date_o, m_draw, m_ver, m_rev, m_date);
        end
    endtask

    task automatic test_wait_states();
        int          dk, pe, w;
        logic [31:0] d0, d1;
        for (int it = 0; it < 6; it++) begin
            w  = (it == 0) ? 3 : int'($urandom_range(0, 4));
            d0 = ($urandom_range(0, 1) == 1) ? 32'h0800_0101 : 32'($urandom);
            d1 = $urandom;
            if ($urandom_range(0, 1) == 1) d1[3:0] = 4'h1;
            if (it == 1) d0 = 32'h0800_0102;
            @(posedge clk); #1;
            run_seq(1'b1, w, -1, d0, d1, dk, pe);
            checks++;
            if (dk !== 2 * w + 5) begin errors++; $display("FAIL ws_latency w=%0d: got %0d expected %0d", w, dk, 2 * w + 5); end
            checks++;
            if (pe !== 0) begin errors++; $display("FAIL ws_protocol w=%0d: got %0d violations expected 0", w, pe); end
            model_good(d0, d1);
            @(posedge clk); #1;
            checks++;
            if ({valid_o, err_o, id_match_o, drawing_number_o, version_o, revision_o, build_date_o} !==
                {m_valid, m_err, m_match, m_draw, m_ver, m_rev, m_date}) begin
                errors++;
                $display("FAIL ws_result it=%0d: got v%b e%b m%b %h/%h/%h/%h expected v%b e%b m%b %h/%h/%h/%h", it,
                         valid_o, err_o, id_match_o, drawing_number_o, version_o, revision_o, build_date_o,
                         m_valid, m_err, m_match, m_draw, m_ver, m_rev, m_date);
            end
        end
    endtask

    task automatic test_slverr();
        int          dk, pe, w;
        logic [31:0] d0, d1;
        for (int errx = 1; errx >= 0; errx--) begin
            w  = int'($urandom_range(0, 2));
            d0 = $urandom;
            d1 = $urandom;
            @(posedge clk); #1;
            run_seq(1'b1, w, errx, d0, d1, dk, pe);
            checks++;
            if (dk !== ((errx == 1) ? 2 * w + 5 : w + 3)) begin
                errors++;
                $display("FAIL slverr_latency x=%0d: got %0d expected %0d", errx, dk, (errx == 1) ? 2 * w + 5 : w + 3);
            end
            model_error();
            @(posedge clk); #1;
            checks++;
            if ({valid_o, err_o, id_match_o, drawing_number_o, version_o, revision_o, build_date_o} !==
                {m_valid, m_err, m_match, m_draw, m_ver, m_rev, m_date}) begin
                errors++;
                $display("FAIL slverr_result x=%0d: got v%b e%b m%b draw=%h expected v%b e%b m%b draw=%h", errx,
                         valid_o, err_o, id_match_o, drawing_number_o, m_valid, m_err, m_match, m_draw);
            end
        end
    endtask

    task automatic test_start_busy();
        int          dk, busy_seen;
        logic [31:0] d0, d1;
        d0 = 32'h0800_0101; d1 = $urandom;
        s_wait = 1; err_xfer = -1; xfer = 0; no_ready = 1'b0; mem0 = d0; mem1 = d1;
        dk = -1;
        @(posedge clk); #1;
        start_i = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done_o) begin dk = k; break; end
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        checks++;
        if (dk !== 7) begin errors++; $display("FAIL busy_latency: got %0d expected 7", dk); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL start_with_done: busy got %b expected 0", busy_o); end
        busy_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (busy_o || m_psel_o) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0) begin errors++; $display("FAIL second_sequence: got %0d busy cycles expected 0", busy_seen); end
        model_good(d0, d1);
        checks++;
        if ({valid_o, id_match_o, drawing_number_o, build_date_o} !== {m_valid, m_match, m_draw, m_date}) begin
            errors++;
            $display("FAIL busy_result: got v%b m%b %h %h expected v%b m%b %h %h", valid_o, id_match_o,
                     drawing_number_o, build_date_o, m_valid, m_match, m_draw, m_date);
        end
    endtask

    task automatic test_reset_mid();
        int dk, pe;
        @(posedge clk); #1;
        no_ready = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({m_psel_o, m_penable_o} !== 2'b11) begin
            errors++;
            $display("FAIL mid_in_access: got psel/penable %b%b expected 11", m_psel_o, m_penable_o);
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        model_reset();
        checks++;
        if ({m_psel_o, m_penable_o, m_paddr_o, busy_o, done_o, valid_o, err_o, id_match_o,
             drawing_number_o, version_o, revision_o, build_date_o} !== 87'h0) begin
            errors++;
            $display("FAIL mid_reset: got psel=%b pen=%b addr=%h busy=%b valid=%b draw=%h expected all 0",
                     m_psel_o, m_penable_o, m_paddr_o, busy_o, valid_o, drawing_number_o);
        end
        rst_i = 1'b0;
        run_seq(1'b0, 0, -1, 32'h0800_0101, 32'h3840_F001, dk, pe);
        checks++;
        if (dk !== 5 || pe !== 0) begin
            errors++;
            $display("FAIL mid_restart: got done=%0d viol=%0d expected 5 and 0", dk, pe);
        end
        model_good(32'h0800_0101, 32'h3840_F001);
        @(posedge clk); #1;
        checks++;
        if ({valid_o, id_match_o, version_o, revision_o, build_date_o} !== {m_valid, m_match, m_ver, m_rev, m_date}) begin
            errors++;
            $display("FAIL mid_restart_fields: got v%b m%b %h/%h/%h expected v%b m%b %h/%h/%h", valid_o, id_match_o,
                     version_o, revision_o, build_date_o, m_valid, m_match, m_ver, m_rev, m_date);
        end
    endtask

    task automatic test_timeout();
        int dk, not_busy;
        logic psel_at_done;
        @(posedge clk); #1;
        no_ready = 1'b1;
        start_i = 1'b1;
        dk = -1; not_busy = 0; psel_at_done = 1'b1;
`ifdef HEADER_BLOCK_RDR_TIMEOUT_EN
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_o) begin dk = k; psel_at_done = m_psel_o; break; end
        end
        checks++;
        if (dk !== 6 || psel_at_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error: got done=%0d psel=%b expected 6 and 0", dk, psel_at_done);
        end
        model_error();
        @(posedge clk); #1;
        checks++;
        if ({valid_o, err_o, id_match_o, drawing_number_o} !== {m_valid, m_err, m_match, m_draw}) begin
            errors++;
            $display("FAIL timeout_flags: got v%b e%b m%b %h expected v%b e%b m%b %h", valid_o, err_o, id_match_o,
                     drawing_number_o, m_valid, m_err, m_match, m_draw);
        end
`else
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (!busy_o || done_o) not_busy++;
        end
        checks++;
        if (not_busy !== 0) begin
            errors++;
            $display("FAIL no_timeout_busy: got %0d idle/done cycles expected 0", not_busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_wait_states();
        test_slverr();
        test_start_busy();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
